hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Scoreboard-based hazard controller for the ID stage of the 5-stage MIPS pipeline.
- Tracks a per-register countdown for in-flight writes and stalls ID until each result reaches WB.
- Forwarding in this pipeline exists only from WB to ID. When a counter expires, the existing WB->ID forward select supplies the data.
- Also sequences the single shared multi-cycle mul/div unit: start pulse, busy tracking, and a structural stall.

Parameters:
- CW, 4: width of every countdown counter. All *_WAIT values must be < 2^CW.
- ALU_WAIT, 2: counter load value for ALU-class producers. Issue at t, WB at t+3, so dependents stall at t+1 and t+2.
- LOAD_WAIT, 2: counter load value for load-class producers. Load data is valid in WB.
- MD_WAIT, 5: counter load value for mul/div producers. This is also the mul/div unit occupancy in cycles.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- RsAddr_id  in  5  rs field of the instruction in ID.
- RtAddr_id  in  5  rt field of the instruction in ID.
- RsUsed_id  in  1  instruction in ID reads rs.
- RtUsed_id  in  1  instruction in ID reads rt.
- InstValid_id  in  1  ID holds a valid instruction.
- RegWrite_id  in  1  instruction in ID writes a register.
- RegWriteAddr_id  in  5  destination register.
- LatClass_id  in  2  producer class: 0 = ALU, 1 = load, 2 = mul/div, 3 = reserved (treated as ALU).
- Stall_id  out  1  hold ID this cycle.
- PcWrite  out  1  equals ~Stall_id.
- IfIdWrite  out  1  equals ~Stall_id.
- IdExBubble  out  1  equals Stall_id; inserts a NOP into ID/EX.
- MdStart  out  1  one-cycle pulse when a mul/div instruction issues.
- MdBusy  out  1  mul/div unit occupied.

Behaviour:
- State:
  - cnt[1..31], CW bits each. Register r0 has no counter and reads as 0.
  - md_cnt, CW bits.
  - FSM MD_IDLE/MD_BUSY, with MdBusy = (state == MD_BUSY).
- Reset (async, immediate):
  - All cnt = 0, md_cnt = 0, state = MD_IDLE.
  - Outputs: Stall_id = 0, PcWrite = 1, IfIdWrite = 1, IdExBubble = 0, MdStart = 0, MdBusy = 0.
- Stall_id is combinational from registered state plus the current ID inputs. It is the OR of the following terms, all gated by InstValid_id:
  - RAW on rs: RsUsed_id and RsAddr_id != 0 and cnt[RsAddr_id] != 0.
  - RAW on rt: the same condition for rt.
  - WAW: RegWrite_id and RegWriteAddr_id != 0 and cnt[RegWriteAddr_id] > load value of LatClass_id.
  - Structural: LatClass_id == 2 and MdBusy.
- Issue = InstValid_id & ~Stall_id.
- Each clock:
  - Every nonzero cnt decrements by 1 and saturates at 0.
  - If Issue & RegWrite_id & RegWriteAddr_id != 0, then cnt[RegWriteAddr_id] is loaded with the class value. The load overrides the decrement of that entry in the same cycle.
  - Writes to r0 never create pending state.
- Mul/div FSM:
  - MD_IDLE: on Issue with LatClass_id == 2, MdStart = 1 (same cycle, combinational), md_cnt <= MD_WAIT, next state MD_BUSY. This transition happens whether or not RegWrite_id is set.
  - MD_BUSY: md_cnt decrements each cycle. When md_cnt == 1 the next state is MD_IDLE, so a back-to-back mul/div can issue in the first MD_IDLE cycle.
  - MdStart is never asserted while in MD_BUSY.
- Latency: a dependent instruction leaves ID in the exact cycle its producer is in WB. At that point cnt is 0 and the WB forward path is active.
- Simultaneous events:
  - Stall cancels Issue. A stalled instruction loads nothing and does not start the mul/div unit.
  - Counters keep decrementing during a stall.
  - rs == rt dependence is checked once; the result is the same.
- Stall is not combinationally dependent on WB inputs, so no timing loop is formed with the forward select.
- Reset mid-operation: all pending state is discarded immediately and Stall_id drops in the same cycle rst rises.

Test Plan:
- Reset: assert rst with random inputs -> Stall_id = 0, PcWrite = 1, MdBusy = 0, MdStart = 0. After release with no issue, all cnt = 0.
- ALU RAW: issue add r3 (class 0) at cycle t; at t+1 ID holds a reader of rs = r3 -> Stall_id = 1 at t+1 and t+2, 0 at t+3. IdExBubble mirrors Stall_id.
- r0 / unused sources: issue a write to r0, then a reader of r0 -> no stall. A reader with RtUsed_id = 0 and rt = pending r3 -> no stall.
- Mul/div: issue mult to r5 at t -> MdStart = 1 at t, MdBusy = 1 for t+1..t+5. An independent ALU instruction at t+1 -> no stall. A reader of r5 at t+1 -> stalls t+1..t+5. A second mul/div at t+1 -> stalls until t+6.
- WAW: mul/div to r7 at t, then an ALU write to r7 at t+1 -> stalls while cnt[7] > 2, i.e. t+1..t+3; issues at t+4 with cnt[7] = 2.
- Reset mid-operation: cnt[9] = 4 with a reader of r9 stalled in ID; pulse rst asynchronously between edges -> Stall_id = 0 immediately, and the reader issues on the next edge after rst drops.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard controller for the 5-stage MIPS pipeline.
// Keeps a per-register countdown of in-flight writes, stalls ID until each
// producer reaches WB (where the WB->ID forward supplies the data), and
// sequences the single shared mul/div unit.
module hazard_stall_controller #(
  parameter int unsigned CW        = 4,
  parameter int unsigned ALU_WAIT  = 2,
  parameter int unsigned LOAD_WAIT = 2,
  parameter int unsigned MD_WAIT   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsAddr_id,
  input  logic [4:0] RtAddr_id,
  input  logic       RsUsed_id,
  input  logic       RtUsed_id,
  input  logic       InstValid_id,
  input  logic       RegWrite_id,
  input  logic [4:0] RegWriteAddr_id,
  input  logic [1:0] LatClass_id,
  output logic       Stall_id,
  output logic       PcWrite,
  output logic       IfIdWrite,
  output logic       IdExBubble,
  output logic       MdStart,
  output logic       MdBusy
);

  typedef enum logic {MD_IDLE, MD_BUSY} mdState_t;

  mdState_t      mdState;
  logic [CW-1:0] mdCnt;
  logic [CW-1:0] cnt [1:31];
  logic [CW-1:0] cntView [32];
  logic [CW-1:0] loadVal;
  logic          rawRs;
  logic          rawRt;
  logic          waw;
  logic          structHaz;
  logic          isMd;
  logic          issue;
  logic          issueWrite;

  // r0 has no counter; expose a 32-entry view with entry 0 fixed at zero.
  always_comb begin
    cntView[0] = '0;
    for (int i = 1; i < 32; i++) cntView[i] = cnt[i];
  end

  // Countdown load value for the producer class in ID (reserved class acts as ALU).
  always_comb begin
    loadVal = CW'(ALU_WAIT);
    case (LatClass_id)
      2'd1:    loadVal = CW'(LOAD_WAIT);
      2'd2:    loadVal = CW'(MD_WAIT);
      default: loadVal = CW'(ALU_WAIT);
    endcase
  end

  // Stall terms: only registered state and ID-stage inputs, never WB inputs.
  always_comb begin
    isMd       = (LatClass_id == 2'd2);
    rawRs      = RsUsed_id && (RsAddr_id != 5'd0) && (cntView[RsAddr_id] != '0);
    rawRt      = RtUsed_id && (RtAddr_id != 5'd0) && (cntView[RtAddr_id] != '0);
    waw        = RegWrite_id && (RegWriteAddr_id != 5'd0)
                 && (cntView[RegWriteAddr_id] > loadVal);
    structHaz  = isMd && MdBusy;
    Stall_id   = InstValid_id && (rawRs || rawRt || waw || structHaz);
    issue      = InstValid_id && !Stall_id && !rst;
    issueWrite = issue && RegWrite_id && (RegWriteAddr_id != 5'd0);
    MdStart    = issue && isMd && (mdState == MD_IDLE);
  end

  assign PcWrite    = ~Stall_id;
  assign IfIdWrite  = ~Stall_id;
  assign IdExBubble = Stall_id;
  assign MdBusy     = (mdState == MD_BUSY);

  // Per-register countdown: issuing write reloads, otherwise saturating decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (issueWrite && (RegWriteAddr_id == 5'(i))) cnt[i] <= loadVal;
        else if (cnt[i] != '0)                        cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // Mul/div occupancy FSM; returns to idle after MD_WAIT busy cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdState <= MD_IDLE;
      mdCnt   <= '0;
    end else begin
      case (mdState)
        MD_IDLE: begin
          if (MdStart) begin
            mdCnt   <= CW'(MD_WAIT);
            mdState <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          mdCnt <= mdCnt - CW'(1);
          if (mdCnt == CW'(1)) mdState <= MD_IDLE;
        end
        default: mdState <= MD_IDLE;
      endcase
    end
  end

endmodule
